// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready, flush, bubble zeroing, 1-cycle latency.
// `define PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_skid #(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  logic              w_in_fire;
  logic              w_out_fire;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;

  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready;
  assign out_data   = r_main_data;
  assign out_ctrl   = r_main_ctrl;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        r_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_in_ready;
  assign occ       = r_state;

  // r_in_ready tracks "next state is not TWO" so upstream never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_NOP;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_NOP;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_in_fire) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= TWO;
            r_in_ready  <= 1'b0;
          end else if (w_out_fire) begin
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
            r_state     <= ONE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_main_data <= '0;
          r_main_ctrl <= CTRL_NOP;
        end
      endcase
    end
  end
`else
  logic r_valid;

  assign out_valid = r_valid;
  assign in_ready  = ~r_valid | out_ready;
  assign occ       = {1'b0, r_valid};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid     <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_NOP;
    end else if (w_in_fire) begin
      r_valid     <= 1'b1;
      r_main_data <= in_data;
      r_main_ctrl <= in_ctrl;
    end else if (w_out_fire) begin
      r_valid     <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_NOP;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid; works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_skid;
  localparam int          DW  = 128;
  localparam int          CW  = 16;
  localparam logic [15:0] NOP = 16'h0013;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occ;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  ent_t sb_q[$];
  ent_t sb_e;

  assign in_ctrl = in_data[15:0] ^ 16'hC3C3;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occ(occ)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs settle at posedge+1, so the negedge sees this cycle's transfers.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      n_pop++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got data=%h ctrl=%h, nothing expected", out_data, out_ctrl);
      end else begin
        sb_e = sb_q.pop_front();
        if (out_data !== sb_e.d || out_ctrl !== sb_e.c) begin
          n_fail++;
          $display("FAIL sb_order: got data=%h ctrl=%h, expected data=%h ctrl=%h",
                   out_data, out_ctrl, sb_e.d, sb_e.c);
        end
      end
    end
    if (rst === 1'b1 || flush === 1'b1) sb_q.delete();
    else if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(ent_t'({in_data, in_ctrl}));
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries still expected, required 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = {16{8'hA5}};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", out_data); end
    if (out_ctrl !== NOP) begin n_fail++; $display("FAIL rst_ctrl: got %h, required %h", out_ctrl, NOP); end
    if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d, required 0", occ); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 128'd1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) in_data = DW'(i + 1);
      else in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        n_fail++;
        $display("FAIL stream_latency[%0d]: got valid=%b data=%h, required valid=1 data=%h",
                 i, out_valid, out_data, DW'(i));
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== NOP) begin
      n_fail++;
      $display("FAIL stream_bubble: got valid=%b data=%h ctrl=%h, required 0/0/%h",
               out_valid, out_data, out_ctrl, NOP);
    end
    drain();
  endtask

  task automatic test_stall();
    int            next = 1;
    int            pop0;
    bit            acc, saw2, saw_nr, prev_stall;
    logic [DW-1:0] held;
    pop0 = n_pop; saw2 = 0; saw_nr = 0; prev_stall = 0; held = '0;
    for (int c = 0; c < 40 && next <= 10; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = 1'b1;
      in_data   = DW'(32'h1000 + next);
      @(negedge clk);
      if (occ === 2'd2) saw2 = 1;
      if (in_ready === 1'b0) saw_nr = 1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, held);
        end
      end
      prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
      held = out_data;
      acc  = (in_valid === 1'b1 && in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) next++;
    end
    drain();
    n_checks++;
    if (n_pop - pop0 != 10) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs, required 10", n_pop - pop0);
    end
`ifdef PIPE_STAGE_SKID_EN
    n_checks++;
    if (!saw2 || !saw_nr) begin
      n_fail++;
      $display("FAIL stall_skid: saw occ2=%0d in_ready0=%0d, required 1/1", saw2, saw_nr);
    end
`endif
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h100;
    @(posedge clk); #1;
    in_data   = 128'h101;
    @(posedge clk); #1;
    in_data   = 128'h102;
    @(negedge clk);
    n_checks++;
`ifdef PIPE_STAGE_SKID_EN
    if (occ !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_two: got occ=%0d in_ready=%b, required 2/0", occ, in_ready);
    end
`else
    if (occ !== 2'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_one: got occ=%0d in_ready=%b, required 1/0", occ, in_ready);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bit leaked = 0;
    fill_stalled();
    flush = 1'b1; in_valid = 1'b1; in_data = 128'h1FF;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d, required 0", occ); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    if (out_ctrl !== NOP || out_data !== '0) begin
      n_fail++; $display("FAIL flush_bubble: got data=%h ctrl=%h, required 0/%h", out_data, out_ctrl, NOP);
    end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked = 1;
    end
    n_checks++;
    if (leaked) begin n_fail++; $display("FAIL flush_drop: got out_valid=1 after flush, required 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_stall();
    fill_stalled();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h2FF;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (occ !== 2'd0) begin n_fail++; $display("FAIL rststall_occ: got %0d, required 0", occ); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rststall_in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 1'b0 || out_ctrl !== NOP) begin
      n_fail++; $display("FAIL rststall_out: got valid=%b ctrl=%h, required 0/%h", out_valid, out_ctrl, NOP);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ready_path();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h200;
    @(posedge clk); #1;
    in_data = 128'h201;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || occ !== 2'd1) begin
      n_fail++; $display("FAIL skid_ready_reg: got in_ready=%b occ=%0d, required 1/1", in_ready, occ);
    end
`else
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL noskid_stall_ready: got %b, required 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL noskid_comb_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_data !== 128'h201 || occ !== 2'd1) begin
      n_fail++; $display("FAIL noskid_replace: got data=%h occ=%0d, required 201/1", out_data, occ);
    end
    @(posedge clk); #1;
`endif
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_stall();
    test_ready_path();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-stage register for the pipelined CPU, generalising the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with valid/ready handshake, stall back-pressure, flush and a two-entry skid buffer. The payload is split into a data field, which is zeroed on a bubble, and a control field, which is forced to a configurable NOP encoding on a bubble. One instance sits between each pair of pipeline stages.

## Interface
- DATA_W, 128, width of data payload (pc, ins, operands, results)
- CTRL_W, 16, width of control payload (RFWr, toReg, DMRd, rd, ...)
- CTRL_NOP, 0, control value presented whenever no valid entry is at the output
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all held entries (branch/jump/exception)
- in_valid  in  1  upstream stage holds a valid instruction
- in_ready  out  1  this stage can accept an entry this cycle
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts this cycle (0 = stall)
- out_data  out  DATA_W  head entry data
- out_ctrl  out  CTRL_W  head entry control; CTRL_NOP when out_valid=0
- occ  out  2  number of held entries (0..2)

## Operation
- in_fire = in_valid & in_ready & ~flush; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. States EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
- EMPTY: in_fire -> ONE, main <= in.
- ONE: in_fire & out_fire -> ONE, main <= in; in_fire & ~out_fire -> TWO, skid <= in; ~in_fire & out_fire -> EMPTY; otherwise hold.
- TWO: in_ready=0, so no accept; out_fire -> ONE, main <= skid; otherwise hold.
- Emptying the main entry sets main data to 0 and main ctrl to CTRL_NOP; out_data/out_ctrl therefore show a bubble whenever out_valid=0.
- While out_valid=1 & out_ready=0, out_data/out_ctrl/out_valid hold stable.
- flush: next state EMPTY, both entries cleared, in_valid ignored that cycle. flush overrides in_fire and out_fire in the same cycle. Downstream may still consume the current head during the flush cycle; that is the downstream stage's responsibility.
- rst: same effect as flush, and has priority over flush.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occ=0, in_ready=1 in the first cycle after rst deasserts.
- Latency: in_fire at edge N -> out_valid=1 with that payload after edge N.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready is a registered output: in_ready = (state != TWO). There is no combinational path from out_ready to in_ready.
- A stall asserted for one cycle absorbs at most one extra entry into the skid; the upstream sees in_ready=0 starting the following cycle.
- Order is strictly FIFO: main, then skid.

## Configuration
- PIPE_STAGE_SKID_EN defined: behaviour as above, two entries, registered in_ready.
- PIPE_STAGE_SKID_EN undefined: skid entry and TWO state removed. in_ready = ~out_valid | out_ready is combinational. occ is 0 or 1. Flush, reset and bubble rules are unchanged; latency is still 1.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and in_data=0xA5... -> out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occ=0, in_ready=1 after release.
- Streaming: out_ready=1, send 8 entries back-to-back with in_data=1..8 -> outputs 1..8 on consecutive cycles, each 1 cycle after accept, with no bubbles.
- Stall: while streaming, drop out_ready for 3 cycles -> occ reaches 2 and in_ready=0. On release, outputs continue in order with no loss and no duplicates (skid-enabled build).
- Flush: in TWO state assert flush together with in_valid=1 -> next cycle occ=0, out_valid=0, out_ctrl=CTRL_NOP, and the input entry is dropped.
- Reset mid-stall: in TWO state assert rst together with flush and out_ready=0 -> all entries cleared, in_ready=1 after release.
- Skid-disabled build: out_ready=0 with occ=1 -> in_ready=0 in the same cycle. Raising out_ready -> in_ready=1 in the same cycle, and a simultaneous accept replaces main.
